// File: rtl/treintaidos_bit_ocho_bit.sv
// Word-to-byte serializer: 32-bit words out as four bytes, MSB first, with a one-word pending buffer.
// Optional even-parity output enabled by defining SERIALIZER_PARITY_EN.
module treintaidos_bit_ocho_bit #(
   parameter logic [7:0] IDLE_BYTE = 8'h00
) (
   input  logic        clk_4f,
   input  logic        reset_L,
   input  logic [31:0] data_in,
   input  logic        valid_in,
   output logic        ready_out,
   output logic [7:0]  data_out,
`ifdef SERIALIZER_PARITY_EN
   output logic        parity_out,
`endif
   output logic        valid_out
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_cnt;
   logic [31:0] r_cur;
   logic [31:0] r_nxt;
   logic        r_nxt_full;
   logic [7:0]  r_data_out;
   logic        r_valid_out;
   logic        r_ready_out;

   logic        w_accept;
   logic        w_load;
   logic        w_to_nxt;
   logic [31:0] w_src;
   logic [1:0]  w_cnt_n;
   logic [31:0] w_cur_n;
   logic [31:0] w_nxt_n;
   logic        w_nxt_full_n;
   logic [7:0]  w_data_n;
   logic        w_valid_n;

   // Byte 0 is the most significant byte of the word.
   function automatic logic [7:0] f_byte(input logic [31:0] word, input logic [1:0] idx);
      case (idx)
         2'd0:    f_byte = word[31:24];
         2'd1:    f_byte = word[23:16];
         2'd2:    f_byte = word[15:8];
         default: f_byte = word[7:0];
      endcase
   endfunction

   function automatic logic f_parity(input logic [7:0] b);
      f_parity = ^b;
   endfunction

   assign w_accept = valid_in & r_ready_out;
   assign w_load   = (r_cnt == 2'd0) & (r_nxt_full | w_accept);
   assign w_src    = r_nxt_full ? r_nxt : data_in;
   // An accepted word bypasses nxt only when it is loaded straight into cur.
   assign w_to_nxt = w_accept & ((r_cnt != 2'd0) | r_nxt_full);

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_load) w_state_nxt = SHIFT;
         default: if ((r_cnt == 2'd0) && !w_load) w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_valid_n    = w_load | (r_cnt != 2'd0);
      w_cur_n      = w_load ? w_src : r_cur;
      w_data_n     = IDLE_BYTE;
      if (w_load)          w_data_n = w_src[31:24];
      else if (w_valid_n)  w_data_n = f_byte(r_cur, r_cnt);
      w_cnt_n      = w_valid_n ? r_cnt + 2'd1 : 2'd0;
      w_nxt_n      = w_to_nxt ? data_in : r_nxt;
      w_nxt_full_n = r_nxt_full;
      if (w_to_nxt)                 w_nxt_full_n = 1'b1;
      else if (w_load && r_nxt_full) w_nxt_full_n = 1'b0;
   end

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         r_cnt       <= 2'd0;
         r_cur       <= 32'd0;
         r_nxt       <= 32'd0;
         r_nxt_full  <= 1'b0;
         r_data_out  <= IDLE_BYTE;
         r_valid_out <= 1'b0;
         r_ready_out <= 1'b1;
      end else begin
         r_cnt       <= w_cnt_n;
         r_cur       <= w_cur_n;
         r_nxt       <= w_nxt_n;
         r_nxt_full  <= w_nxt_full_n;
         r_data_out  <= w_data_n;
         r_valid_out <= w_valid_n;
         r_ready_out <= !w_nxt_full_n;
      end
   end

`ifdef SERIALIZER_PARITY_EN
   logic r_parity_out;

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) r_parity_out <= 1'b0;
      else          r_parity_out <= w_valid_n & f_parity(w_data_n);
   end

   assign parity_out = r_parity_out;
`endif

   assign data_out  = r_data_out;
   assign valid_out = r_valid_out;
   assign ready_out = r_ready_out;

endmodule
